// File: rtl/lfsr_rng_scheduler.sv
// rtl/lfsr_rng_scheduler.sv - round-robin shared Fibonacci LFSR random source
//
// Purpose: one LFSR serves NREQ requesters. Each grant hands out the current
// LFSR word and advances the LFSR once, so no two grants see the same word.
// Seeding forces an all-zero seed to 1 and can be followed by a warm-up run.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   seed_load  single-cycle pulse, loads seed (beats arbitration that cycle)
//   seed       seed value sampled with seed_load
//   req        per-requester level request
//   gnt        registered one-hot grant, one cycle wide
//   rdata      registered random word for the granted requester
//   rvalid     high together with any gnt bit
//   busy       high whenever the FSM is not serving
//   seed_err   sticky: last loaded seed was all-zero
module lfsr_rng_scheduler #(
  parameter int                LENGTH = 16,
  parameter logic [LENGTH-1:0] TAPS   = LENGTH'(16'hD008),
  parameter int                NREQ   = 4,
  parameter int                WARMUP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LENGTH-1:0] seed,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [LENGTH-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              seed_err
);

  localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]      WU_LAST  = 8'(WARMUP - 1);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_SERVE} state_t;

  state_t            state;
  state_t            state_next;
  logic [LENGTH-1:0] lfsr;
  logic [LENGTH-1:0] lfsr_step;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_next;
  logic [PW-1:0]     win_idx;
  logic [PW:0]       cand;
  logic              win_found;
  logic              do_grant;
  logic [NREQ-1:0]   win_onehot;
  logic [7:0]        wcnt;

  // Feedback is the parity of the tapped bits plus bit 0, shifted in at the top.
  assign lfsr_step = {^{lfsr & TAPS, lfsr[0]}, lfsr[LENGTH-1:1]};

  // Rotating priority search starting at ptr; cand is one bit wider so the
  // wrap subtraction never overflows.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!win_found && req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  assign ptr_next   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
  assign win_onehot = NREQ'(1) << win_idx;
  assign do_grant   = (state == ST_SERVE) && !seed_load && win_found;
  assign busy       = (state != ST_SERVE);

  always_comb begin
    state_next = state;
    if (seed_load) begin
      state_next = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;
    end else if (state == ST_WARMUP && wcnt == WU_LAST) begin
      state_next = ST_SERVE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr     <= LENGTH'(1);
      ptr      <= '0;
      wcnt     <= '0;
      gnt      <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      seed_err <= 1'b0;
    end else begin
      gnt    <= '0;
      rvalid <= 1'b0;
      if (seed_load) begin
        // An all-zero state would lock up the LFSR, so substitute 1.
        lfsr     <= (seed == '0) ? LENGTH'(1) : seed;
        seed_err <= (seed == '0);
        wcnt     <= '0;
      end else if (state == ST_WARMUP) begin
        lfsr <= lfsr_step;
        wcnt <= wcnt + 8'd1;
      end else if (do_grant) begin
        gnt    <= win_onehot;
        rdata  <= lfsr;
        rvalid <= 1'b1;
        lfsr   <= lfsr_step;
        ptr    <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rng_scheduler.sv
// tb/tb_lfsr_rng_scheduler.sv - scoreboard bench for lfsr_rng_scheduler
module tb_lfsr_rng_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic [3:0]  req = '0;

  logic [3:0]  gnt0, gnt1;
  logic [15:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, busy0, busy1, err0, err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_rng_scheduler #(.LENGTH(16), .TAPS(16'hD008), .NREQ(4), .WARMUP(0)) u0 (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .gnt(gnt0), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0), .seed_err(err0)
  );

  lfsr_rng_scheduler #(.LENGTH(16), .TAPS(16'hD008), .NREQ(4), .WARMUP(4)) u1 (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .gnt(gnt1), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1), .seed_err(err1)
  );

  typedef struct {logic [3:0] g; logic [15:0] d;} gexp_t;
  typedef struct {logic busy; logic err; logic rv;} sexp_t;

  gexp_t       q0[$], q1[$];
  sexp_t       s0[$], s1[$];
  logic [19:0] log0[$], log1[$];

  // Reference model: mode 0 idle, 1 warming up, 2 serving.
  int          m_mode[2];
  logic [15:0] m_lfsr[2];
  int          m_ptr[2];
  int          m_rem[2];
  logic        m_err[2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_next(logic [15:0] s);
    int ones;
    ones = $countones(s & 16'hD008) + int'(s[0]);
    return (s >> 1) | (16'(ones % 2) << 15);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_mode[u] = 0;
      m_lfsr[u] = 16'h0001;
      m_ptr[u]  = 0;
      m_rem[u]  = 0;
      m_err[u]  = 1'b0;
    end
  endtask

  task automatic model_edge(int u, int wu, output sexp_t st, output bit g, output gexp_t ge);
    int idx;
    g    = 0;
    ge.g = '0;
    ge.d = '0;
    if (rst) begin
      if (seed_load) begin
        m_lfsr[u] = (seed == 16'h0) ? 16'h0001 : seed;
        m_err[u]  = (seed == 16'h0);
        if (wu == 0) m_mode[u] = 2;
        else begin
          m_mode[u] = 1;
          m_rem[u]  = wu;
        end
      end else if (m_mode[u] == 1) begin
        m_lfsr[u] = ref_next(m_lfsr[u]);
        m_rem[u]--;
        if (m_rem[u] == 0) m_mode[u] = 2;
      end else if (m_mode[u] == 2 && req != 4'h0) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr[u] + k) % 4;
          if (!g && req[idx]) begin
            g    = 1;
            ge.g = 4'(1 << idx);
            ge.d = m_lfsr[u];
            m_ptr[u] = (idx + 1) % 4;
          end
        end
        m_lfsr[u] = ref_next(m_lfsr[u]);
      end
    end
    st.busy = (m_mode[u] != 2);
    st.err  = m_err[u];
    st.rv   = g;
  endtask

  // Called just after a falling edge: drive inputs, predict the next rising edge.
  task automatic cycle(logic sl, logic [15:0] sd, logic [3:0] rq);
    sexp_t st;
    bit    g;
    gexp_t ge;
    seed_load = sl;
    seed      = sd;
    req       = rq;
    model_edge(0, 0, st, g, ge);
    s0.push_back(st);
    if (g) q0.push_back(ge);
    model_edge(1, 4, st, g, ge);
    s1.push_back(st);
    if (g) q1.push_back(ge);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 16'h0, 4'h0);
    rst = 1'b1;
  endtask

  sexp_t mst;
  gexp_t mge;

  always @(posedge clk) begin
    #1;
    if (s0.size() > 0) begin
      mst = s0.pop_front();
      chk("u0_busy", busy0, mst.busy);
      chk("u0_seed_err", err0, mst.err);
      chk("u0_rvalid", rvalid0, mst.rv);
      if (mst.rv && q0.size() > 0) begin
        mge = q0.pop_front();
        chk("u0_gnt", gnt0, mge.g);
        chk("u0_rdata", rdata0, mge.d);
      end
      if (rvalid0) log0.push_back({gnt0, rdata0});
    end
    if (s1.size() > 0) begin
      mst = s1.pop_front();
      chk("u1_busy", busy1, mst.busy);
      chk("u1_seed_err", err1, mst.err);
      chk("u1_rvalid", rvalid1, mst.rv);
      if (mst.rv && q1.size() > 0) begin
        mge = q1.pop_front();
        chk("u1_gnt", gnt1, mge.g);
        chk("u1_rdata", rdata1, mge.d);
      end
      if (rvalid1) log1.push_back({gnt1, rdata1});
    end
  end

  initial begin
    logic [19:0] exp1 [6];
    logic [19:0] exp2 [5];
    int          n;
    exp1 = '{{4'h1, 16'h0001}, {4'h1, 16'h8000}, {4'h1, 16'hC000},
             {4'h1, 16'h6000}, {4'h1, 16'hB000}, {4'h1, 16'h5800}};
    exp2 = '{{4'h1, 16'h0001}, {4'h2, 16'h8000}, {4'h4, 16'hC000},
             {4'h8, 16'h6000}, {4'h1, 16'hB000}};
    model_reset();

    #12;
    chk("rst_gnt", gnt0, 4'h0);
    chk("rst_rvalid", rvalid0, 1'b0);
    chk("rst_rdata", rdata0, 16'h0);
    chk("rst_busy", busy0, 1'b1);
    chk("rst_seed_err", err0, 1'b0);
    chk("rst_busy_u1", busy1, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Single requester stream, WARMUP 0 and 4 side by side.
    cycle(1'b1, 16'h0001, 4'h0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, 4'h1);
    chk("seq1_len", log0.size(), 6);
    n = (log0.size() < 6) ? log0.size() : 6;
    for (int i = 0; i < n; i++) chk($sformatf("seq1_word%0d", i), log0[i], exp1[i]);
    chk("warm_len", log1.size(), 2);
    if (log1.size() > 0) chk("warm_first", log1[0], {4'h1, 16'hB000});

    // All four requesting: rotation from ptr 0.
    pulse_reset();
    log0.delete();
    cycle(1'b1, 16'h0001, 4'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 4'hF);
    chk("seq2_len", log0.size(), 5);
    n = (log0.size() < 5) ? log0.size() : 5;
    for (int i = 0; i < n; i++) chk($sformatf("seq2_word%0d", i), log0[i], exp2[i]);

    // Zero seed substitution and seed_err clearing.
    log0.delete();
    cycle(1'b1, 16'h0000, 4'h0);
    chk("zero_seed_err", err0, 1'b1);
    cycle(1'b0, 16'h0, 4'h1);
    cycle(1'b1, 16'h1234, 4'h0);
    chk("seed_err_clear", err0, 1'b0);
    cycle(1'b0, 16'h0, 4'h1);
    chk("seq3_len", log0.size(), 2);
    if (log0.size() == 2) begin
      chk("zero_seed_word", log0[0][15:0], 16'h0001);
      chk("reseed_word", log0[1][15:0], 16'h1234);
    end

    // seed_load beats a pending request; ptr survives the reload.
    pulse_reset();
    cycle(1'b1, 16'h0001, 4'h0);
    cycle(1'b0, 16'h0, 4'hF);
    cycle(1'b0, 16'h0, 4'hF);
    n = log0.size();
    cycle(1'b1, 16'hABCD, 4'hF);
    chk("load_blocks_grant", log0.size(), n);
    cycle(1'b0, 16'h0, 4'hF);
    chk("reload_len", log0.size(), n + 1);
    if (log0.size() == n + 1) chk("reload_word", log0[n], {4'h4, 16'hABCD});

    // Reset mid-stream: outputs clear at once, nothing granted until reseeded.
    cycle(1'b0, 16'h0, 4'hF);
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_gnt", gnt0, 4'h0);
    chk("mid_rst_rvalid", rvalid0, 1'b0);
    chk("mid_rst_busy", busy0, 1'b1);
    chk("mid_rst_rdata", rdata0, 16'h0);
    @(negedge clk);
    cycle(1'b0, 16'h0, 4'hF);
    rst = 1'b1;
    n = log0.size();
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 4'hF);
    chk("no_grant_unseeded", log0.size(), n);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0)
        cycle(1'b1, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 4'($urandom));
      else
        cycle(1'b0, 16'h0, 4'($urandom));
    end
    cycle(1'b0, 16'h0, 4'h0);
    cycle(1'b0, 16'h0, 4'h0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
